// File: rtl/eth_pause_rx.sv
// Receive-side 802.3x PAUSE detector: parses DA/type/opcode/quanta and runs the
// transmit hold-off timer. Build option ETH_PAUSE_UNICAST_EN also accepts DA == MAC.
module eth_pause_rx #(
  parameter int Tp          = 1,
  parameter int SLOT_CYCLES = 128
) (
  input  logic        MRxClk,
  input  logic        RxReset,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  input  logic        RxStartFrm,
  input  logic        RxEndFrm,
  input  logic        ReceiveEnd,
  input  logic        ReceivedPacketGood,
  input  logic        ReceivedLengthOK,
  input  logic        RxFlow,
  input  logic        DlyCrcEn,
  input  logic [47:0] MAC,
  output logic        Pause,
  output logic        ReceivedPauseFrm,
  output logic        AddressOK,
  output logic [15:0] PauseTimer
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PARSE, S_MATCH, S_DISCARD} state_t;

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [15:0]     r_quanta;
  logic            r_mc_ok;
  logic            r_addr_ok;
  logic            r_pause_frm;
  logic [15:0]     r_timer;
  logic [SW-1:0]   r_slot;
  logic            r_pause;

  logic            w_start;
  logic [4:0]      w_cnt_next;
  logic [4:0]      w_off;
  logic [4:0]      w_base;
  logic [4:0]      w_rel;
  logic            w_active;
  logic            w_is_da;
  logic            w_mc_prev;
  logic            w_mc_hit;
  logic            w_uc_hit;
  logic            w_da_bad;
  logic            w_fix_bad;
  logic            w_bad;
  logic            w_load;
  logic            w_unused;

  function automatic logic [7:0] f_mc_byte(input logic [4:0] i);
    case (i)
      5'd0:    f_mc_byte = 8'h01;
      5'd1:    f_mc_byte = 8'h80;
      5'd2:    f_mc_byte = 8'hC2;
      5'd5:    f_mc_byte = 8'h01;
      default: f_mc_byte = 8'h00;
    endcase
  endfunction

  assign w_start    = RxValid & RxStartFrm;
  assign w_cnt_next = (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
  assign w_off      = w_start ? 5'd0 : w_cnt_next;
  // A delayed-CRC prefix pushes every header field four bytes later
  assign w_base     = DlyCrcEn ? 5'd4 : 5'd0;
  assign w_rel      = w_off - w_base;
  assign w_active   = RxValid & (w_off >= w_base) &
                      (w_start | ((r_state == S_PARSE) & ~ReceiveEnd));
  assign w_is_da    = (w_rel < 5'd6);
  assign w_mc_prev  = w_start | r_mc_ok;
  assign w_mc_hit   = w_mc_prev & (RxData == f_mc_byte(w_rel));

`ifdef ETH_PAUSE_UNICAST_EN
  logic r_uc_ok;
  logic [7:0] w_mac_byte;
  always_comb begin
    w_mac_byte = 8'h00;
    case (w_rel)
      5'd0:    w_mac_byte = MAC[47:40];
      5'd1:    w_mac_byte = MAC[39:32];
      5'd2:    w_mac_byte = MAC[31:24];
      5'd3:    w_mac_byte = MAC[23:16];
      5'd4:    w_mac_byte = MAC[15:8];
      5'd5:    w_mac_byte = MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end
  assign w_uc_hit = (w_start | r_uc_ok) & (RxData == w_mac_byte);
`else
  assign w_uc_hit = 1'b0;
`endif

  assign w_da_bad = ~w_mc_hit & ~w_uc_hit;

  always_comb begin
    w_fix_bad = 1'b0;
    case (w_rel)
      5'd12:   w_fix_bad = (RxData != 8'h88);
      5'd13:   w_fix_bad = (RxData != 8'h08);
      5'd14:   w_fix_bad = (RxData != 8'h00);
      5'd15:   w_fix_bad = (RxData != 8'h01);
      default: w_fix_bad = 1'b0;
    endcase
  end

  assign w_bad  = w_is_da ? w_da_bad : w_fix_bad;
  assign w_load = ReceiveEnd & ~w_start & (r_state == S_MATCH) &
                  ReceivedPacketGood & ReceivedLengthOK & RxFlow;

  // Frame parser FSM
  always_ff @(posedge MRxClk or posedge RxReset) begin
    if (RxReset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_quanta    <= 16'd0;
      r_mc_ok     <= 1'b0;
      r_addr_ok   <= 1'b0;
      r_pause_frm <= 1'b0;
`ifdef ETH_PAUSE_UNICAST_EN
      r_uc_ok     <= 1'b0;
`endif
    end else begin
      r_pause_frm <= w_load;
      if (RxValid)
        r_cnt <= w_start ? 5'd0 : w_cnt_next;

      if (w_start) begin
        r_state   <= S_PARSE;
        r_quanta  <= 16'd0;
        r_mc_ok   <= 1'b1;
        r_addr_ok <= 1'b0;
`ifdef ETH_PAUSE_UNICAST_EN
        r_uc_ok   <= 1'b1;
`endif
      end else if (ReceiveEnd) begin
        r_state <= S_IDLE;
      end

      if (w_active) begin
        if (w_is_da) begin
          r_mc_ok <= w_mc_hit;
`ifdef ETH_PAUSE_UNICAST_EN
          r_uc_ok <= w_uc_hit;
`endif
          if ((w_rel == 5'd5) && !w_da_bad)
            r_addr_ok <= 1'b1;
        end
        if (w_bad) begin
          r_state <= S_DISCARD;
        end else if (w_rel == 5'd16) begin
          r_quanta[15:8] <= RxData;
        end else if (w_rel == 5'd17) begin
          r_quanta[7:0] <= RxData;
          r_state       <= S_MATCH;
        end
      end
    end
  end

  // Hold-off timer: one quantum per SLOT_CYCLES clocks; load beats decrement
  always_ff @(posedge MRxClk or posedge RxReset) begin
    if (RxReset) begin
      r_timer <= 16'd0;
      r_slot  <= '0;
      r_pause <= 1'b0;
    end else begin
      r_pause <= RxFlow & (r_timer != 16'd0);
      if (!RxFlow) begin
        r_timer <= 16'd0;
        r_slot  <= '0;
      end else if (w_load) begin
        r_timer <= r_quanta;
        r_slot  <= '0;
      end else if (r_timer != 16'd0) begin
        if (r_slot == SW'(SLOT_CYCLES - 1)) begin
          r_slot  <= '0;
          r_timer <= r_timer - 16'd1;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end
    end
  end

  assign w_unused = ^{MAC, RxEndFrm, (Tp != 0)};

  assign Pause            = r_pause;
  assign ReceivedPauseFrm = r_pause_frm;
  assign AddressOK        = r_addr_ok;
  assign PauseTimer       = r_timer;

endmodule

// File: tb/tb_eth_pause_rx.sv
// Directed bench for eth_pause_rx: table of whole-frame vectors plus
// hand-written sequences for pause length, cancel and reset corners.
module tb_eth_pause_rx;

  localparam logic [47:0] MC  = 48'h0180C2000001;
  localparam logic [47:0] UC  = 48'h00123456789A;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;

  logic        MRxClk = 1'b0;
  logic        RxReset = 1'b1;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0, RxStartFrm = 1'b0, RxEndFrm = 1'b0;
  logic        ReceiveEnd = 1'b0, ReceivedPacketGood = 1'b0, ReceivedLengthOK = 1'b0;
  logic        RxFlow = 1'b1, DlyCrcEn = 1'b0;
  logic [47:0] MAC = UC;
  logic        Pause, ReceivedPauseFrm, AddressOK;
  logic [15:0] PauseTimer;

  int errors = 0;
  int checks = 0;

  eth_pause_rx #(.Tp(1), .SLOT_CYCLES(128)) dut (
    .MRxClk(MRxClk), .RxReset(RxReset), .RxData(RxData), .RxValid(RxValid),
    .RxStartFrm(RxStartFrm), .RxEndFrm(RxEndFrm), .ReceiveEnd(ReceiveEnd),
    .ReceivedPacketGood(ReceivedPacketGood), .ReceivedLengthOK(ReceivedLengthOK),
    .RxFlow(RxFlow), .DlyCrcEn(DlyCrcEn), .MAC(MAC), .Pause(Pause),
    .ReceivedPauseFrm(ReceivedPauseFrm), .AddressOK(AddressOK), .PauseTimer(PauseTimer)
  );

  always #5 MRxClk = ~MRxClk;

  typedef struct {
    string       name;
    bit          dly;
    logic [47:0] da;
    logic [15:0] typ, op, q;
    bit          good, lenok, flow;
    bit          exp_pulse;
    logic [15:0] exp_timer;
    bit          exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MRxClk);
    #1;
  endtask

  task automatic send_frame(input bit dly, input logic [47:0] da, input logic [15:0] typ,
                            input logic [15:0] op, input logic [15:0] q, input int nmax);
    logic [7:0] b[$];
    logic [47:0] sa;
    int n;
    b = {};
    sa = 48'h020000000001;
    if (dly) repeat (4) b.push_back(8'h55);
    for (int i = 5; i >= 0; i--) b.push_back(da[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(sa[8*i +: 8]);
    b.push_back(typ[15:8]); b.push_back(typ[7:0]);
    b.push_back(op[15:8]);  b.push_back(op[7:0]);
    b.push_back(q[15:8]);   b.push_back(q[7:0]);
    repeat (4) b.push_back(8'h00);
    n = (nmax < b.size()) ? nmax : b.size();
    DlyCrcEn = dly;
    for (int i = 0; i < n; i++) begin
      RxValid = 1'b1; RxData = b[i];
      RxStartFrm = (i == 0); RxEndFrm = (i == b.size() - 1);
      tick();
    end
    RxValid = 1'b0; RxStartFrm = 1'b0; RxEndFrm = 1'b0;
  endtask

  task automatic end_frame(input bit good, input bit lenok);
    ReceiveEnd = 1'b1; ReceivedPacketGood = good; ReceivedLengthOK = lenok;
    tick();
    ReceiveEnd = 1'b0; ReceivedPacketGood = 1'b0; ReceivedLengthOK = 1'b0;
  endtask

  task automatic good_frame(input logic [15:0] q);
    send_frame(1'b0, MC, 16'h8808, 16'h0001, q, 99);
    end_frame(1'b1, 1'b1);
  endtask

  task automatic clear_timer();
    RxFlow = 1'b0;
    tick();
    RxFlow = 1'b1;
  endtask

  vec_t vt[10];
  int   pcnt;

  initial begin
`ifdef ETH_PAUSE_UNICAST_EN
    localparam bit UNI = 1'b1;
`else
    localparam bit UNI = 1'b0;
`endif
    vt[0] = '{"mc_q2",      0, MC, 16'h8808, 16'h0001, 16'h0002, 1, 1, 1, 1, 16'h0002, 1};
    vt[1] = '{"bad_crc",    0, MC, 16'h8808, 16'h0001, 16'h0002, 0, 1, 1, 0, 16'h0000, 1};
    vt[2] = '{"bad_len",    0, MC, 16'h8808, 16'h0001, 16'h0002, 1, 0, 1, 0, 16'h0000, 1};
    vt[3] = '{"flow_off",   0, MC, 16'h8808, 16'h0001, 16'h0002, 1, 1, 0, 0, 16'h0000, 1};
    vt[4] = '{"dly_ok",     1, MC, 16'h8808, 16'h0001, 16'h0010, 1, 1, 1, 1, 16'h0010, 1};
    vt[5] = '{"dly_ipv4",   1, MC, 16'h0800, 16'h0001, 16'h0010, 1, 1, 1, 0, 16'h0000, 1};
    vt[6] = '{"bad_opcode", 0, MC, 16'h8808, 16'h0002, 16'h0007, 1, 1, 1, 0, 16'h0000, 1};
    vt[7] = '{"unicast",    0, UC, 16'h8808, 16'h0001, 16'h0005, 1, 1, 1, UNI,
              UNI ? 16'h0005 : 16'h0000, UNI};
    vt[8] = '{"broadcast",  0, BC, 16'h8808, 16'h0001, 16'h0005, 1, 1, 1, 0, 16'h0000, 0};
    vt[9] = '{"q_abcd",     0, MC, 16'h8808, 16'h0001, 16'hABCD, 1, 1, 1, 1, 16'hABCD, 1};

    repeat (3) tick();
    chk("rst_pause", Pause, 0);
    chk("rst_pulse", ReceivedPauseFrm, 0);
    chk("rst_addr", AddressOK, 0);
    chk("rst_timer", PauseTimer, 0);
    RxReset = 1'b0;
    tick();

    foreach (vt[k]) begin
      RxFlow = vt[k].flow;
      send_frame(vt[k].dly, vt[k].da, vt[k].typ, vt[k].op, vt[k].q, 99);
      end_frame(vt[k].good, vt[k].lenok);
      chk({vt[k].name, "_pulse"}, ReceivedPauseFrm, vt[k].exp_pulse);
      chk({vt[k].name, "_timer"}, PauseTimer, vt[k].exp_timer);
      chk({vt[k].name, "_addr"}, AddressOK, vt[k].exp_addr);
      tick();
      chk({vt[k].name, "_pulse_end"}, ReceivedPauseFrm, 0);
      chk({vt[k].name, "_pause"}, Pause, vt[k].exp_timer != 16'h0);
      clear_timer();
      chk({vt[k].name, "_flow_clr"}, PauseTimer, 0);
    end

    // Two quanta -> Pause high for exactly 256 clocks
    good_frame(16'h0002);
    pcnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (Pause) pcnt++;
    end
    chk("pause_len", pcnt, 256);
    chk("pause_len_timer", PauseTimer, 0);

    // Zero-quanta frame cancels a running pause
    good_frame(16'h00FF);
    repeat (50) tick();
    chk("cancel_pre_pause", Pause, 1);
    chk("cancel_pre_timer", PauseTimer, 16'h00FF);
    good_frame(16'h0000);
    chk("cancel_pulse", ReceivedPauseFrm, 1);
    chk("cancel_timer", PauseTimer, 0);
    tick();
    chk("cancel_pause", Pause, 0);

    // Reset at byte 15 of a frame
    send_frame(1'b0, MC, 16'h8808, 16'h0001, 16'h0009, 15);
    chk("rst15_addr_pre", AddressOK, 1);
    RxReset = 1'b1;
    #1;
    chk("rst15_addr", AddressOK, 0);
    chk("rst15_timer", PauseTimer, 0);
    tick();
    RxReset = 1'b0;
    tick();
    good_frame(16'h0003);
    chk("rst15_next_pulse", ReceivedPauseFrm, 1);
    chk("rst15_next_timer", PauseTimer, 16'h0003);

    // Reset in the middle of a pause
    repeat (10) tick();
    chk("rstp_pre_pause", Pause, 1);
    RxReset = 1'b1;
    #1;
    chk("rstp_pause", Pause, 0);
    chk("rstp_timer", PauseTimer, 0);
    chk("rstp_addr", AddressOK, 0);
    tick();
    RxReset = 1'b0;
    tick();
    good_frame(16'h0001);
    chk("rstp_next_timer", PauseTimer, 16'h0001);
    chk("rstp_next_addr", AddressOK, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
